fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Single-clock write-side controller for the framebuffer.
//  Shares the framebuffer write port between two pixel requesters using a
//  valid/ready handshake and round-robin arbitration.
//  Includes a clear engine that sweeps every visible pixel address with a
//  fill colour.
//  Outputs drive the framebuffer write port: clk_wr=clk, en_wr/wrea/addr_wr/din.
// PARAMETERS
//  ADDR_WIDTH  17     framebuffer address width
//  DATA_WIDTH  12     pixel width (RGB444)
//  NUM_PIXELS  76800  visible pixels (320x240); valid addresses 0..NUM_PIXELS-1
// PORTS
//  clk        in   1           single clock (framebuffer write clock)
//  rst        in   1           asynchronous, active-high reset
//  clr_start  in   1           pulse: start a clear sweep
//  clr_color  in   DATA_WIDTH  fill colour, sampled with clr_start
//  clr_busy   out  1           clear sweep in progress
//  clr_done   out  1           one-cycle pulse at the end of a sweep
//  req0_valid in   1           requester 0 has a pixel
//  req0_addr  in   ADDR_WIDTH  requester 0 pixel address
//  req0_data  in   DATA_WIDTH  requester 0 pixel value
//  req0_ready out  1           requester 0 transfer accepted this cycle
//  req1_*     same as req0_*   requester 1
//  fb_en      out  1           framebuffer write enable (en_wr)
//  fb_we      out  1           framebuffer write strobe (wrea); equals fb_en
//  fb_addr    out  ADDR_WIDTH  framebuffer write address
//  fb_din     out  DATA_WIDTH  framebuffer write data
//  oob_err    out  1           sticky: an out-of-range address was dropped
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; all outputs 0; RR pointer favours req0; sweep counter 0.
//  State machine:
//   - IDLE -> CLEAR on clr_start.
//   - CLEAR -> IDLE after the write to address NUM_PIXELS-1.
//  Arbitration (IDLE only):
//   - reqN_ready is combinational: high when IDLE, clr_start=0, and N is granted.
//   - If only one requester is valid, it is granted.
//   - If both are valid, the requester not granted last is granted.
//   - The pointer updates only on a completed transfer (valid & ready).
//   - Exactly one transfer per cycle, at most.
//   - A valid request holding its addr/data while stalled is required of the
//     requester; the block does not check this.
//  Write latency:
//   - A transfer at edge T produces fb_en=fb_we=1, fb_addr, fb_din on
//     cycle T+1 (registered).
//   - fb_en=0 on cycles with no write.
//  Out-of-range addresses:
//   - addr >= NUM_PIXELS: the handshake completes (ready=1), no write is
//     issued, and oob_err is set.
//   - oob_err is cleared only by rst.
//  Clear:
//   - clr_start in IDLE has priority over requests in the same cycle; both
//     readies are 0 that cycle.
//   - clr_color is latched at that edge.
//   - On the next NUM_PIXELS cycles, writes go to addresses 0,1,...,
//     NUM_PIXELS-1 with the latched colour, one per cycle.
//   - clr_busy=1 exactly during those cycles; readies stay 0.
//   - clr_done=1 for one cycle, the cycle after the final write. State is
//     IDLE then, so requests may be accepted in that cycle.
//   - clr_start while clr_busy=1 is ignored. The colour and counter are
//     unchanged.
//  Mid-operation reset:
//   - Aborts the sweep immediately. fb_en=0, clr_busy=0, and no clr_done
//     is issued.
//  Widths:
//   - Sweep counter is ADDR_WIDTH bits and never exceeds NUM_PIXELS-1
//     (no wrap).
//   - NUM_PIXELS <= 2**ADDR_WIDTH is required.
// TESTING
//  1. req0 only, addr=5, data=12'hF00 -> ready same cycle; next cycle fb_en=1,
//     fb_addr=5, fb_din=F00.
//  2. Both valid continuously for 4 cycles, after reset -> grants 0,1,0,1;
//     fb_addr sequence matches; no cycle with 2 readies.
//  3. clr_start with clr_color=12'h00F, NUM_PIXELS=16 override -> 16 writes,
//     addr 0..15, din=00F; clr_busy 16 cycles; clr_done on cycle 17;
//     readies 0 throughout.
//  4. clr_start and req1_valid in the same cycle -> req1_ready=0; sweep runs;
//     req1 is accepted on the clr_done cycle.
//  5. req0_addr=NUM_PIXELS -> ready=1, fb_en stays 0, oob_err=1 and stays 1.
//  6. rst asserted mid-sweep (addr 7) -> fb_en=0 and clr_busy=0 immediately;
//     no clr_done; a new clr_start restarts at addr 0.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: framebuffer write-port controller.
// Two pixel requesters share one write port through a valid/ready handshake
// with round-robin arbitration. A clear engine can take over the port and
// sweep every visible address with a fill colour. Write outputs are registered,
// so a transfer accepted on one edge appears on the port during the next cycle.
module fb_write_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 12,
    parameter int NUM_PIXELS = 76800
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_color,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  fb_en,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [DATA_WIDTH-1:0] fb_din,
    output logic                  oob_err
);

    // One extra bit so NUM_PIXELS == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0]   NUM_PIX_W = (ADDR_WIDTH+1)'(NUM_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;      // 0: req0 wins a tie, 1: req1 wins
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;        // sweep address currently on the port
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  fb_en_q, fb_en_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic [DATA_WIDTH-1:0] fb_din_q, fb_din_d;
    logic                  done_q, done_d;
    logic                  oob_q, oob_d;

    logic                  arb_ok;
    logic                  gnt0, gnt1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grant decode: requesters are served only when idle and no clear is starting.
    always_comb begin
        arb_ok   = (state_q == ST_IDLE) && !clr_start && !rst;
        gnt0     = arb_ok && req0_valid && (!req1_valid || !prio_q);
        gnt1     = arb_ok && req1_valid && (!req0_valid ||  prio_q);
        sel_addr = gnt1 ? req1_addr : req0_addr;
        sel_data = gnt1 ? req1_data : req0_data;
    end

    // Next-state, sweep sequencing and write-port staging.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        color_d   = color_q;
        fb_en_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_din_d  = fb_din_q;
        done_d    = 1'b0;
        oob_d     = oob_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    // First sweep write is issued straight away so that the
                    // port is busy for exactly NUM_PIXELS cycles.
                    state_d   = ST_CLEAR;
                    cnt_d     = '0;
                    color_d   = clr_color;
                    fb_en_d   = 1'b1;
                    fb_addr_d = '0;
                    fb_din_d  = clr_color;
                end else if (gnt0 || gnt1) begin
                    // The loser of this transfer gets priority on the next tie.
                    prio_d = gnt0;
                    if ({1'b0, sel_addr} < NUM_PIX_W) begin
                        fb_en_d   = 1'b1;
                        fb_addr_d = sel_addr;
                        fb_din_d  = sel_data;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q + ADDR_WIDTH'(1);
                    fb_en_d   = 1'b1;
                    fb_addr_d = cnt_q + ADDR_WIDTH'(1);
                    fb_din_d  = color_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            color_q   <= '0;
            fb_en_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_din_q  <= '0;
            done_q    <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            color_q   <= color_d;
            fb_en_q   <= fb_en_d;
            fb_addr_q <= fb_addr_d;
            fb_din_q  <= fb_din_d;
            done_q    <= done_d;
            oob_q     <= oob_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign clr_busy   = (state_q == ST_CLEAR);
    assign clr_done   = done_q;
    assign fb_en      = fb_en_q;
    assign fb_we      = fb_en_q;
    assign fb_addr    = fb_addr_q;
    assign fb_din     = fb_din_q;
    assign oob_err    = oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter with a small framebuffer (16 pixels).
module tb_fb_write_arbiter;
    localparam int AW = 6;
    localparam int DW = 12;
    localparam int NP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy, clr_done;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          fb_en, fb_we, oob_err;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_din;

    fb_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PIXELS(NP)) dut (
        .clk(clk), .rst(rst), .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: clear cycles remaining, done-pulse due, tie priority, sticky error.
    int  m_rem;
    bit  m_done, m_prio, m_oob;
    bit  acc0, acc1;

    // Requester-side state: a request stays posted until it is accepted.
    bit            p0, p1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            rate0, rate1;

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(3) == 0) return AW'($urandom_range(2**AW-1, NP));
        return AW'($urandom_range(NP-1, 0));
    endfunction

    task automatic model_reset();
        m_rem = 0; m_done = 0; m_prio = 0; m_oob = 0;
        acc0 = 0; acc1 = 0; p0 = 0; p1 = 0;
        exp_q.delete();
    endtask

    // Predict this cycle's outputs and the effect of the coming edge.
    task automatic eval();
        bit e0, e1, busy;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        e0 = 0; e1 = 0;
        busy = (m_rem > 0);
        chk("clr_busy", clr_busy, busy);
        chk("clr_done", clr_done, m_done);
        chk("oob_err", oob_err, m_oob);
        m_done = 0;
        if (busy) begin
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (clr_start) begin
            for (int i = 0; i < NP; i++) exp_q.push_back('{a: AW'(i), d: clr_color});
            m_rem = NP;
        end else begin
            if (p0 && p1) begin e0 = !m_prio; e1 = m_prio; end
            else begin e0 = p0; e1 = p1; end
            if (e0 || e1) begin
                a = e0 ? a0 : a1;
                d = e0 ? d0 : d1;
                if (a < NP) exp_q.push_back('{a: a, d: d});
                else m_oob = 1;
                m_prio = e0;
            end
        end
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("one_grant", req0_ready & req1_ready, 0);
        acc0 = e0; acc1 = e1;
    endtask

    task automatic step(input bit start, input logic [DW-1:0] col);
        @(posedge clk); #1;
        if (acc0) p0 = 0;
        if (acc1) p1 = 0;
        acc0 = 0; acc1 = 0;
        if (!p0 && $urandom_range(99) < rate0) begin p0 = 1; a0 = rand_addr(); d0 = DW'($urandom); end
        if (!p1 && $urandom_range(99) < rate1) begin p1 = 1; a1 = rand_addr(); d1 = DW'($urandom); end
        req0_valid = p0; req0_addr = a0; req0_data = d0;
        req1_valid = p1; req1_addr = a1; req1_data = d1;
        clr_start = start; clr_color = col;
        #1 eval();
    endtask

    task automatic idle(input int n);
        rate0 = 0; rate1 = 0;
        repeat (n) step(0, '0);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1;
        clr_start = 0; req0_valid = 0; req1_valid = 0;
        model_reset();
        #1;
        chk("rst_fb_en", fb_en, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_oob", oob_err, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_din", fb_din, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        repeat (cycles) @(posedge clk);
        #1 rst = 0;
    endtask

    // Monitor: every port write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            chk("fb_we", fb_we, fb_en);
            if (fb_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: got addr %0h din %0h, expected none", fb_addr, fb_din);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("fb_addr", fb_addr, w.a);
                    chk("fb_din", fb_din, w.d);
                end
            end
        end
    end

    initial begin
        rst = 1; clr_start = 0; clr_color = '0;
        req0_valid = 0; req1_valid = 0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        rate0 = 0; rate1 = 0;
        model_reset();
        do_reset(2);

        // single in-range write from req0
        idle(2);
        p0 = 1; a0 = 6'd5; d0 = 12'hF00;
        idle(3);

        // both requesters valid back to back after reset: alternating grants
        do_reset(1);
        rate0 = 100; rate1 = 100;
        repeat (4) step(0, '0);
        idle(3);

        // full sweep with a fixed colour
        step(1, 12'h00F);
        idle(NP + 3);

        // clear start wins over a same-cycle request, which is then served on the done cycle
        p1 = 1; a1 = 6'd3; d1 = 12'hABC;
        step(1, 12'h123);
        idle(NP + 3);

        // out-of-range address: handshake completes, nothing written, error sticks
        p0 = 1; a0 = 6'(NP); d0 = 12'h555;
        idle(4);
        p1 = 1; a1 = 6'd9; d1 = 12'h777;
        idle(3);

        // reset while the sweep is on address 7, then a fresh sweep from 0
        step(1, 12'h0F0);
        idle(7);
        do_reset(1);
        idle(NP + 3);
        step(1, 12'h321);
        idle(NP + 3);

        // randomized traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            rate0 = 60; rate1 = 60;
            step($urandom_range(99) < 3, DW'($urandom));
        end
        idle(NP + 5);

        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
